bpu: RTL and testbench
======================

# bpu

Branch prediction unit for the in-order core's fetch stage. Each cycle it predicts whether the fetch PC holds a taken branch and, if so, supplies the predicted target. It uses a bimodal table of 2-bit saturating counters (BHT) and a direct-mapped branch target buffer (BTB). It is trained by the execute-stage branch outcome (the branch comparison result plus the computed target) and reports mispredictions so fetch can redirect.

## Interface
Parameters:
- BHT_DEPTH, 64, number of 2-bit counters; power of two.
- BTB_DEPTH, 16, number of BTB entries; power of two; must not exceed BHT_DEPTH.

Ports:
- clock  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low.
- fetch_valid  in  1  fetch_pc is valid this cycle.
- fetch_hold  in  1  fetch stalled; prediction outputs hold their values.
- fetch_pc  in  32  PC being fetched.
- pred_valid  out  1  prediction outputs are valid.
- pred_taken  out  1  predicted taken.
- pred_addr  out  32  predicted target; meaningful only when pred_taken=1.
- upd_valid  in  1  a resolved conditional branch is presented.
- upd_pc  in  32  PC of the resolved branch.
- upd_branch  in  1  actual outcome from the branch comparison unit.
- upd_target  in  32  computed branch target.
- upd_pred_taken  in  1  prediction carried down the pipe with this branch.
- upd_pred_addr  in  32  predicted target carried down the pipe with this branch.
- mispred  out  1  registered misprediction flag, one-cycle pulse.
- mispred_addr  out  32  correct redirect PC.

## Operation
- BHT index = pc[log2(BHT_DEPTH)+1:2]. BTB index = pc[log2(BTB_DEPTH)+1:2]. BTB tag = pc[31:log2(BTB_DEPTH)+2].
- BTB entry fields: valid, tag, target.
- Counter encoding: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
- Prediction: pred_taken = BTB hit (valid and tag match) AND counter[1]. pred_addr = BTB target on a hit, otherwise 0.
- Update when upd_valid=1:
  - Counter saturating increment if upd_branch=1, decrement if upd_branch=0. The counter stays at 11 on increment and 00 on decrement.
  - If upd_branch=1, the BTB entry is overwritten with valid=1, the upd_pc tag, and upd_target.
  - If upd_branch=0, the BTB is untouched.
- Mispredict condition: upd_valid AND (upd_branch != upd_pred_taken OR (upd_branch AND upd_pred_addr != upd_target)).
- mispred_addr = upd_target if upd_branch=1, else upd_pc+4 (modulo 2^32).
- When upd_valid=0, mispred=0 and mispred_addr holds its previous value.

## Timing
- Prediction latency is 1 cycle: fetch_pc sampled at edge N appears on pred_* after edge N.
- pred_valid is the registered fetch_valid.
- fetch_hold=1: pred_valid, pred_taken and pred_addr hold, and fetch inputs are ignored. Updates proceed regardless of fetch_hold.
- Update latency: tables are written at the edge where upd_valid=1 and become visible to a lookup sampled at the next edge.
- Simultaneous lookup and update to the same index: the lookup returns the pre-update contents (read-before-write). There is no forwarding.
- mispred and mispred_addr are registered one cycle after the upd_valid edge. mispred is a single-cycle pulse per offending update.
- Reset (asynchronous, any time, including mid-update) takes effect immediately:
  - all counters = 01;
  - all BTB valid = 0, tags and targets = 0;
  - pred_valid = 0, pred_taken = 0, pred_addr = 0;
  - mispred = 0, mispred_addr = 0.
- First prediction after reset deassertion appears one edge after fetch_valid=1 is sampled.

## Structure
- Shared package wires holds:
  - bpu_in_type and bpu_out_type structs grouping the ports above;
  - counter encoding constants (strongly/weakly not-taken/taken);
  - default depth constants.
- Sub-module bpu_btb: the tag/target/valid array, with a registered read port, a write port and a hit output.
- The BHT counters and the mispredict logic stay in bpu.

## Test plan
Defaults BHT_DEPTH=64, BTB_DEPTH=16.
- After reset, fetch 0x100 -> next cycle pred_valid=1, pred_taken=0, pred_addr=0.
- One update with upd_pc=0x100, upd_branch=1, upd_target=0x80 -> counter 01->10. Fetch 0x100 next cycle -> pred_taken=1, pred_addr=0x80.
- Same training, then fetch 0x140 (same BTB index 0, tag 5 vs 4) -> pred_taken=0.
- Four taken updates on 0x100 then one not-taken -> counter 11->10, so fetch 0x100 is still taken. Two more not-taken -> 00, so fetch 0x100 is not taken.
- Update upd_pc=0x100, upd_branch=0, upd_pred_taken=1 -> next cycle mispred=1, mispred_addr=0x104, and the following cycle mispred=0.
- Same-cycle lookup and update on 0x100 -> the prediction reflects the old state. Then assert reset while pred_valid=1 -> all outputs 0 immediately, and fetch 0x100 after release -> not taken.

Source files
------------

// File: rtl/bpu_pkg.sv
// Shared types and constants for the bimodal branch predictor: port-grouping
// structs, 2-bit counter encodings and default table depths.
package bpu_pkg;

    localparam int PC_W          = 32;
    localparam int BHT_DEPTH_DEF = 64;
    localparam int BTB_DEPTH_DEF = 16;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    typedef struct packed {
        logic            fetch_valid;
        logic            fetch_hold;
        logic [PC_W-1:0] fetch_pc;
        logic            upd_valid;
        logic [PC_W-1:0] upd_pc;
        logic            upd_branch;
        logic [PC_W-1:0] upd_target;
        logic            upd_pred_taken;
        logic [PC_W-1:0] upd_pred_addr;
    } bpu_in_type;

    typedef struct packed {
        logic            pred_valid;
        logic            pred_taken;
        logic [PC_W-1:0] pred_addr;
        logic            mispred;
        logic [PC_W-1:0] mispred_addr;
    } bpu_out_type;

    // Saturating 2-bit counter step toward the resolved outcome.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
        end
        return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/bpu_if.sv
// Fetch-side prediction and execute-side training signals of the branch predictor.
interface bpu_if;
    import bpu_pkg::*;

    logic            fetch_valid;
    logic            fetch_hold;
    logic [PC_W-1:0] fetch_pc;
    logic            pred_valid;
    logic            pred_taken;
    logic [PC_W-1:0] pred_addr;
    logic            upd_valid;
    logic [PC_W-1:0] upd_pc;
    logic            upd_branch;
    logic [PC_W-1:0] upd_target;
    logic            upd_pred_taken;
    logic [PC_W-1:0] upd_pred_addr;
    logic            mispred;
    logic [PC_W-1:0] mispred_addr;

    modport master (
        output fetch_valid, fetch_hold, fetch_pc,
        output upd_valid, upd_pc, upd_branch, upd_target, upd_pred_taken, upd_pred_addr,
        input  pred_valid, pred_taken, pred_addr, mispred, mispred_addr
    );

    modport slave (
        input  fetch_valid, fetch_hold, fetch_pc,
        input  upd_valid, upd_pc, upd_branch, upd_target, upd_pred_taken, upd_pred_addr,
        output pred_valid, pred_taken, pred_addr, mispred, mispred_addr
    );

endinterface

// File: rtl/bpu_btb.sv
// Direct-mapped branch target buffer: registered lookup (hit + target) and a
// single write port; writes land at the same edge, so lookups see old contents.
module bpu_btb
    import bpu_pkg::*;
#(
    parameter int DEPTH = BTB_DEPTH_DEF,
    localparam int IW   = $clog2(DEPTH),
    localparam int TW   = PC_W - IW - 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            rd_en,
    input  logic [IW-1:0]   rd_idx,
    input  logic [TW-1:0]   rd_tag,
    input  logic            wr_en,
    input  logic [IW-1:0]   wr_idx,
    input  logic [TW-1:0]   wr_tag,
    input  logic [PC_W-1:0] wr_target,
    output logic            hit,
    output logic [PC_W-1:0] rd_target
);

    logic            valid_q  [DEPTH];
    logic            valid_d  [DEPTH];
    logic [TW-1:0]   tag_q    [DEPTH];
    logic [TW-1:0]   tag_d    [DEPTH];
    logic [PC_W-1:0] target_q [DEPTH];
    logic [PC_W-1:0] target_d [DEPTH];
    logic            hit_q, hit_d;
    logic [PC_W-1:0] rd_target_q, rd_target_d;

    always_comb begin
        valid_d     = valid_q;
        tag_d       = tag_q;
        target_d    = target_q;
        hit_d       = hit_q;
        rd_target_d = rd_target_q;
        if (wr_en) begin
            valid_d[wr_idx]  = 1'b1;
            tag_d[wr_idx]    = wr_tag;
            target_d[wr_idx] = wr_target;
        end
        if (rd_en) begin
            hit_d       = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
            rd_target_d = target_q[rd_idx];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
            end
            hit_q       <= 1'b0;
            rd_target_q <= '0;
        end else begin
            valid_q     <= valid_d;
            tag_q       <= tag_d;
            target_q    <= target_d;
            hit_q       <= hit_d;
            rd_target_q <= rd_target_d;
        end
    end

    assign hit       = hit_q;
    assign rd_target = rd_target_q;

endmodule

// File: rtl/bpu.sv
// Branch prediction unit: bimodal 2-bit counter table plus BTB, trained by the
// execute-stage outcome, with a registered one-cycle mispredict/redirect output.
module bpu
    import bpu_pkg::*;
#(
    parameter int BHT_DEPTH = BHT_DEPTH_DEF,
    parameter int BTB_DEPTH = BTB_DEPTH_DEF
) (
    input  logic clock,
    input  logic reset,
    bpu_if.slave bus
);

    localparam int BHT_IW = $clog2(BHT_DEPTH);
    localparam int BTB_IW = $clog2(BTB_DEPTH);
    localparam int TAG_W  = PC_W - BTB_IW - 2;

    bpu_in_type  in_s;
    bpu_out_type out_s;

    always_comb begin
        in_s.fetch_valid    = bus.fetch_valid;
        in_s.fetch_hold     = bus.fetch_hold;
        in_s.fetch_pc       = bus.fetch_pc;
        in_s.upd_valid      = bus.upd_valid;
        in_s.upd_pc         = bus.upd_pc;
        in_s.upd_branch     = bus.upd_branch;
        in_s.upd_target     = bus.upd_target;
        in_s.upd_pred_taken = bus.upd_pred_taken;
        in_s.upd_pred_addr  = bus.upd_pred_addr;
    end

    logic [1:0]        ctr_q [BHT_DEPTH];
    logic [1:0]        ctr_d [BHT_DEPTH];
    logic              ctr_msb_q, ctr_msb_d;
    logic              pred_valid_q, pred_valid_d;
    logic              mispred_q, mispred_d;
    logic [PC_W-1:0]   mispred_addr_q, mispred_addr_d;
    logic [BHT_IW-1:0] fetch_bht_idx, upd_bht_idx;
    logic              lookup_en;
    logic              btb_hit;
    logic [PC_W-1:0]   btb_target;
    logic              unused_pc_lsbs;

    assign fetch_bht_idx  = in_s.fetch_pc[BHT_IW+1:2];
    assign upd_bht_idx    = in_s.upd_pc[BHT_IW+1:2];
    assign lookup_en      = !in_s.fetch_hold;
    assign unused_pc_lsbs = ^{in_s.fetch_pc[1:0], in_s.upd_pc[1:0]};

    bpu_btb #(.DEPTH(BTB_DEPTH)) u_btb (
        .clock     (clock),
        .reset     (reset),
        .rd_en     (lookup_en),
        .rd_idx    (in_s.fetch_pc[BTB_IW+1:2]),
        .rd_tag    (in_s.fetch_pc[PC_W-1:BTB_IW+2]),
        .wr_en     (in_s.upd_valid && in_s.upd_branch),
        .wr_idx    (in_s.upd_pc[BTB_IW+1:2]),
        .wr_tag    (in_s.upd_pc[PC_W-1:BTB_IW+2]),
        .wr_target (in_s.upd_target),
        .hit       (btb_hit),
        .rd_target (btb_target)
    );

    always_comb begin
        ctr_d          = ctr_q;
        ctr_msb_d      = ctr_msb_q;
        pred_valid_d   = pred_valid_q;
        mispred_d      = 1'b0;
        mispred_addr_d = mispred_addr_q;
        if (lookup_en) begin
            ctr_msb_d    = ctr_q[fetch_bht_idx][1];
            pred_valid_d = in_s.fetch_valid;
        end
        if (in_s.upd_valid) begin
            ctr_d[upd_bht_idx] = ctr_next(ctr_q[upd_bht_idx], in_s.upd_branch);
            // A taken branch is also wrong if it went somewhere other than predicted.
            mispred_d = (in_s.upd_branch != in_s.upd_pred_taken) ||
                        (in_s.upd_branch && (in_s.upd_pred_addr != in_s.upd_target));
            mispred_addr_d = in_s.upd_branch ? in_s.upd_target : in_s.upd_pc + 32'd4;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                ctr_q[i] <= CTR_WNT;
            end
            ctr_msb_q      <= 1'b0;
            pred_valid_q   <= 1'b0;
            mispred_q      <= 1'b0;
            mispred_addr_q <= '0;
        end else begin
            ctr_q          <= ctr_d;
            ctr_msb_q      <= ctr_msb_d;
            pred_valid_q   <= pred_valid_d;
            mispred_q      <= mispred_d;
            mispred_addr_q <= mispred_addr_d;
        end
    end

    always_comb begin
        out_s.pred_valid   = pred_valid_q;
        out_s.pred_taken   = btb_hit && ctr_msb_q;
        out_s.pred_addr    = btb_hit ? btb_target : '0;
        out_s.mispred      = mispred_q;
        out_s.mispred_addr = mispred_addr_q;
    end

    assign bus.pred_valid   = out_s.pred_valid;
    assign bus.pred_taken   = out_s.pred_taken;
    assign bus.pred_addr    = out_s.pred_addr;
    assign bus.mispred      = out_s.mispred;
    assign bus.mispred_addr = out_s.mispred_addr;

endmodule

// File: tb/tb_bpu.sv
// Bench for bpu: directed vector table, reset corner sequence, then random
// traffic checked against an array-based behavioural predictor model.
module tb_bpu;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bpu_if bus();

    bpu #(.BHT_DEPTH(64), .BTB_DEPTH(16)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        fv, fh;
        logic [31:0] fpc;
        logic        uv;
        logic [31:0] upc;
        logic        ub;
        logic [31:0] utgt;
        logic        upt;
        logic [31:0] upa;
        logic        e_pv, e_pt;
        logic [31:0] e_pa;
        logic        e_mp;
        logic [31:0] e_ma;
    } vec_t;

    vec_t tbl[22];

    task automatic drive(input logic fv, input logic fh, input logic [31:0] fpc,
                         input logic uv, input logic [31:0] upc, input logic ub,
                         input logic [31:0] utgt, input logic upt, input logic [31:0] upa);
        bus.fetch_valid    = fv;
        bus.fetch_hold     = fh;
        bus.fetch_pc       = fpc;
        bus.upd_valid      = uv;
        bus.upd_pc         = upc;
        bus.upd_branch     = ub;
        bus.upd_target     = utgt;
        bus.upd_pred_taken = upt;
        bus.upd_pred_addr  = upa;
    endtask

    task automatic check_all(input string tag, input logic pv, input logic pt,
                             input logic [31:0] pa, input logic mp, input logic [31:0] ma);
        check({tag, "_pred_valid"}, 32'(bus.pred_valid), 32'(pv));
        if (pv) begin
            check({tag, "_pred_taken"}, 32'(bus.pred_taken), 32'(pt));
            check({tag, "_pred_addr"}, bus.pred_addr, pa);
        end
        check({tag, "_mispred"}, 32'(bus.mispred), 32'(mp));
        check({tag, "_mispred_addr"}, bus.mispred_addr, ma);
    endtask

    // Behavioural model: counters as integers 0..3, BTB as plain arrays.
    int          m_ctr [64];
    bit          m_bv  [16];
    logic [31:0] m_btag[16];
    logic [31:0] m_btgt[16];
    logic        e_pv, e_pt, e_mp;
    logic [31:0] e_pa, e_ma;

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_ctr[i] = 1;
        for (int i = 0; i < 16; i++) begin
            m_bv[i] = 0; m_btag[i] = 0; m_btgt[i] = 0;
        end
        e_pv = 0; e_pt = 0; e_pa = 0; e_mp = 0; e_ma = 0;
    endtask

    task automatic model_clock();
        int bi, hi;
        bit hit;
        if (!bus.fetch_hold) begin
            bi   = int'((bus.fetch_pc / 4) % 16);
            hi   = int'((bus.fetch_pc / 4) % 64);
            hit  = m_bv[bi] && (m_btag[bi] == bus.fetch_pc / 64);
            e_pv = bus.fetch_valid;
            e_pt = hit && (m_ctr[hi] >= 2);
            e_pa = hit ? m_btgt[bi] : 32'h0;
        end
        e_mp = 0;
        if (bus.upd_valid) begin
            bi = int'((bus.upd_pc / 4) % 16);
            hi = int'((bus.upd_pc / 4) % 64);
            e_mp = (bus.upd_branch != bus.upd_pred_taken) ||
                   (bus.upd_branch && bus.upd_pred_addr != bus.upd_target);
            e_ma = bus.upd_branch ? bus.upd_target : bus.upd_pc + 32'd4;
            if (bus.upd_branch) begin
                if (m_ctr[hi] < 3) m_ctr[hi] = m_ctr[hi] + 1;
                m_bv[bi] = 1; m_btag[bi] = bus.upd_pc / 64; m_btgt[bi] = bus.upd_target;
            end else if (m_ctr[hi] > 0) begin
                m_ctr[hi] = m_ctr[hi] - 1;
            end
        end
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] base;
        base = ($urandom_range(0, 3) == 0) ? 32'h1000_0000 : 32'h0;
        return base + 32'($urandom_range(0, 3)) * 64 + 32'($urandom_range(0, 15)) * 4;
    endfunction

    initial begin
        //          fv fh fpc        uv upc           ub utgt      upt upa       pv pt pa        mp ma
        tbl[0]  = '{1, 0, 32'h100, 0, 32'h0,        0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   0, 32'h0};
        tbl[1]  = '{1, 0, 32'h100, 1, 32'h100,      1, 32'h80,  0, 32'h0,   1, 0, 32'h0,   1, 32'h80};
        tbl[2]  = '{1, 0, 32'h100, 0, 32'h0,        0, 32'h0,   0, 32'h0,   1, 1, 32'h80,  0, 32'h80};
        tbl[3]  = '{1, 0, 32'h140, 0, 32'h0,        0, 32'h0,   0, 32'h0,   1, 0, 32'h0,   0, 32'h80};
        tbl[4]  = '{0, 0, 32'h100, 0, 32'h0,        0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0, 32'h80};
        tbl[5]  = '{1, 0, 32'h100, 0, 32'h0,        0, 32'h0,   0, 32'h0,   1, 1, 32'h80,  0, 32'h80};
        tbl[6]  = '{1, 1, 32'h140, 0, 32'h0,        0, 32'h0,   0, 32'h0,   1, 1, 32'h80,  0, 32'h80};
        tbl[7]  = '{0, 1, 32'h140, 1, 32'h100,      0, 32'h0,   1, 32'h80,  1, 1, 32'h80,  1, 32'h104};
        tbl[8]  = '{1, 0, 32'h100, 0, 32'h0,        0, 32'h0,   0, 32'h0,   1, 0, 32'h80,  0, 32'h104};
        tbl[9]  = '{1, 0, 32'h100, 1, 32'h100,      1, 32'h80,  0, 32'h0,   1, 0, 32'h80,  1, 32'h80};
        tbl[10] = '{1, 0, 32'h100, 1, 32'h100,      1, 32'h80,  1, 32'h80,  1, 1, 32'h80,  0, 32'h80};
        tbl[11] = '{1, 0, 32'h100, 1, 32'h100,      1, 32'h80,  1, 32'h90,  1, 1, 32'h80,  1, 32'h80};
        tbl[12] = '{1, 0, 32'h100, 1, 32'h100,      1, 32'h200, 1, 32'h80,  1, 1, 32'h80,  1, 32'h200};
        tbl[13] = '{1, 0, 32'h100, 1, 32'h100,      0, 32'h0,   1, 32'h200, 1, 1, 32'h200, 1, 32'h104};
        tbl[14] = '{1, 0, 32'h100, 1, 32'h100,      0, 32'h0,   1, 32'h200, 1, 1, 32'h200, 1, 32'h104};
        tbl[15] = '{1, 0, 32'h100, 1, 32'h100,      0, 32'h0,   0, 32'h0,   1, 0, 32'h200, 0, 32'h104};
        tbl[16] = '{1, 0, 32'h100, 1, 32'h100,      0, 32'h0,   0, 32'h0,   1, 0, 32'h200, 0, 32'h104};
        tbl[17] = '{1, 0, 32'h100, 1, 32'h100,      1, 32'h200, 0, 32'h0,   1, 0, 32'h200, 1, 32'h200};
        tbl[18] = '{1, 0, 32'h100, 1, 32'h100,      1, 32'h200, 0, 32'h0,   1, 0, 32'h200, 1, 32'h200};
        tbl[19] = '{1, 0, 32'h100, 0, 32'h0,        0, 32'h0,   0, 32'h0,   1, 1, 32'h200, 0, 32'h200};
        tbl[20] = '{0, 0, 32'h0,   1, 32'hFFFFFFFC, 0, 32'h0,   1, 32'h0,   0, 0, 32'h0,   1, 32'h0};
        tbl[21] = '{0, 0, 32'h0,   0, 32'h0,        0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0, 32'h0};

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 0, 0, 0, 0, 0);
        check("reset_pred_taken", 32'(bus.pred_taken), 32'h0);
        check("reset_pred_addr", bus.pred_addr, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].fv, tbl[i].fh, tbl[i].fpc, tbl[i].uv, tbl[i].upc,
                  tbl[i].ub, tbl[i].utgt, tbl[i].upt, tbl[i].upa);
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), tbl[i].e_pv, tbl[i].e_pt, tbl[i].e_pa,
                      tbl[i].e_mp, tbl[i].e_ma);
        end

        // Counter for 0x100 is weakly taken with BTB target 0x200; mispredict then reset mid-update.
        drive(1, 0, 32'h100, 1, 32'h100, 0, 32'h0, 1, 32'h200);
        @(posedge clk);
        #1;
        check_all("pre_rst", 1, 1, 32'h200, 1, 32'h104);
        drive(1, 0, 32'h100, 1, 32'h100, 1, 32'h300, 0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_pred_valid", 32'(bus.pred_valid), 32'h0);
        check("async_rst_pred_taken", 32'(bus.pred_taken), 32'h0);
        check("async_rst_pred_addr", bus.pred_addr, 32'h0);
        check("async_rst_mispred", 32'(bus.mispred), 32'h0);
        check("async_rst_mispred_addr", bus.mispred_addr, 32'h0);
        @(posedge clk);
        #1;
        drive(1, 0, 32'h100, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_rst", 1, 0, 32'h0, 0, 32'h0);
        check("post_rst_pred_taken", 32'(bus.pred_taken), 32'h0);

        // Random traffic against the behavioural model.
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 800; c++) begin
            logic [31:0] tgt;
            tgt = $urandom & 32'hFFFF_FFFC;
            drive(($urandom_range(0, 9) < 8), ($urandom_range(0, 4) == 0), rand_pc(),
                  $urandom_range(0, 1) == 1, rand_pc(), $urandom_range(0, 1) == 1, tgt,
                  $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 2) == 0) ? ($urandom & 32'hFFFF_FFFC) : tgt);
            model_clock();
            @(posedge clk);
            #1;
            check_all($sformatf("rand%0d", c), e_pv, e_pt, e_pa, e_mp, e_ma);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
